shift_seq_ctrl: RTL

Sequencing controller placed directly upstream of the team's N-bit load/shift register. Drives the register's `Load`, `Shift` and `SerIn` inputs. On a start request it issues one load cycle, then performs a programmed number of shifts. Each shift consumes one bit from a valid/ready serial source. A one-cycle `done` pulse follows the last shift. Used by datapaths that must load a word and then shift a counted number of serial bits into it.

---
 rtl/shift_seq_ctrl_if.sv | 38 +++
 rtl/shift_seq_ctrl.sv | 98 +++++++++
 2 files changed

// File: rtl/shift_seq_ctrl_if.sv
// Handshake/strobe bundle between shift_seq_ctrl and its requester, serial source and register.
// Carries the optional abort request when SHIFT_SEQ_CTRL_ABORT_EN is defined.
interface shift_seq_ctrl_if #(
    parameter int unsigned N = 8
);
    localparam int unsigned CW = $clog2(N + 1);

    logic          start;
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
    logic          abort;
`endif
    logic [CW-1:0] shamt;
    logic          ser_valid;
    logic          ser_bit;
    logic          ser_ready;
    logic          Load;
    logic          Shift;
    logic          SerIn;
    logic          busy;
    logic          done;
    logic [CW-1:0] remaining;

    modport master (
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
        output abort,
`endif
        output start, shamt, ser_valid, ser_bit,
        input  ser_ready, Load, Shift, SerIn, busy, done, remaining
    );

    modport slave (
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
        input  abort,
`endif
        input  start, shamt, ser_valid, ser_bit,
        output ser_ready, Load, Shift, SerIn, busy, done, remaining
    );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Load-then-shift sequencer for an N-bit load/shift register fed from a valid/ready serial source.
// Optional feature: define SHIFT_SEQ_CTRL_ABORT_EN to add the abort input.
module shift_seq_ctrl #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = $clog2(N + 1)
) (
    input logic              clk,
    input logic              rst,
    shift_seq_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] rem_q, rem_d;

    logic load, shift, ser_in, ser_ready, busy, done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // Strobes decode from state; Shift/SerIn pass the serial source straight through in SHIFT.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        load      = 1'b0;
        shift     = 1'b0;
        ser_in    = 1'b0;
        ser_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    rem_d   = (bus.shamt > CW'(N)) ? CW'(N) : bus.shamt;
                end
            end
            S_LOAD: begin
                busy    = 1'b1;
                load    = 1'b1;
                state_d = (rem_q == '0) ? S_DONE : S_SHIFT;
            end
            S_SHIFT: begin
                busy      = 1'b1;
                ser_ready = 1'b1;
                shift     = bus.ser_valid;
                ser_in    = bus.ser_bit;
                if (bus.ser_valid) begin
                    rem_d = rem_q - CW'(1);
                    if (rem_q == CW'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef SHIFT_SEQ_CTRL_ABORT_EN
        // Abort drops the operation silently: no strobes this cycle, no done afterwards.
        if (bus.abort && (state_q == S_LOAD || state_q == S_SHIFT)) begin
            state_d = S_IDLE;
            rem_d   = '0;
            load    = 1'b0;
            shift   = 1'b0;
            ser_in  = 1'b0;
        end
`endif
    end

    assign bus.Load      = load;
    assign bus.Shift     = shift;
    assign bus.SerIn     = ser_in;
    assign bus.ser_ready = ser_ready;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.remaining = rem_q;

endmodule
